except_arb: RTL

//  Shares one except (special-number classifier) unit between two operand requesters.

---
 rtl/except_arb.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/except_arb.sv
// except_arb: round-robin sharing of one except (special-number classifier)
// unit between two operand requesters. Accepted operand pairs are registered
// into the except unit, tracked through its fixed latency with a tagged valid
// pipe, and their realigned flags are queued in an in-order response FIFO.
// Credits (free FIFO slots minus in-flight ops) throttle acceptance, so the
// FIFO can never overflow and the except side never has to stall.
//
// Handshake rule (all three ports): a transfer happens on a rising clk edge
// exactly when valid and ready are both high in the cycle before that edge;
// the producer holds valid and payload stable until that transfer.
//
// Optional feature macro: EXC_STICKY_EN. When defined, the {inf,ind,qnan,snan}
// flags of every FIFO push are OR-accumulated into sticky_flags (sticky_clr
// clears them). When undefined, sticky_flags is tied to zero.
module except_arb #(
  parameter int LAT        = 2,
  parameter int RBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_opa,
  input  logic [31:0] req0_opb,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_opa,
  input  logic [31:0] req1_opb,
  output logic [31:0] exu_opa,
  output logic [31:0] exu_opb,
  input  logic [7:0]  exu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_flags,
  output logic [3:0]  sticky_flags,
  input  logic        sticky_clr
);

  localparam int AW = $clog2(RBUF_DEPTH);
  localparam int CW = $clog2(RBUF_DEPTH + 1);

  // last_grant = 1 means requester 1 won most recently, so requester 0 is favoured next
  logic          last_grant;
  logic [CW-1:0] credits;
  logic          grant0;
  logic          grant1;
  logic          has_credit;
  logic          accept;
  logic          accept_id;

  logic [LAT:0]  pipe_v;
  logic [LAT:0]  pipe_id;
  logic [1:0]    nan_d;
  logic          push;
  logic          push_id;
  logic [7:0]    push_flags;
  logic          pop;

  logic [8:0]    mem [RBUF_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Round-robin grant: the lone valid requester wins, ties go to the one not granted last
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  assign has_credit = (credits != '0);
  assign req0_ready = grant0 & has_credit & ~rst;
  assign req1_ready = grant1 & has_credit & ~rst;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign accept_id  = req1_valid & req1_ready;

  // Issue register and round-robin pointer; operands hold when nothing is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exu_opa    <= '0;
      exu_opb    <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      exu_opa    <= accept_id ? req1_opa : req0_opa;
      exu_opb    <= accept_id ? req1_opb : req0_opb;
      last_grant <= accept_id;
    end
  end

  // Tagged valid pipe mirroring the except latency; stage LAT lines up with the flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v  <= {pipe_v[LAT-1:0], accept};
      pipe_id <= {pipe_id[LAT-1:0], accept_id};
    end
  end

  // opa_nan/opb_nan come out one cycle early; delay them to meet the other six flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) nan_d <= '0;
    else     nan_d <= exu_flags[3:2];
  end

  assign push       = pipe_v[LAT];
  assign push_id    = pipe_id[LAT];
  assign push_flags = {exu_flags[7:4], nan_d, exu_flags[1:0]};
  assign rsp_valid  = (wr_ptr != rd_ptr);
  assign pop        = rsp_valid & rsp_ready;

  // FIFO storage; pushes cannot overflow because acceptance is credit limited
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RBUF_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= {push_id, push_flags};
    end
  end

  // FIFO pointers with a wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign rsp_id    = mem[rd_ptr[AW-1:0]][8];
  assign rsp_flags = mem[rd_ptr[AW-1:0]][7:0];

  // Credits: one consumed per accept, one returned per response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CW'(RBUF_DEPTH);
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

`ifdef EXC_STICKY_EN
  // Sticky accumulation of {inf,ind,qnan,snan}; a coincident clear keeps only the pushed flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= push ? push_flags[7:4] : 4'b0000;
    end else if (push) begin
      sticky_flags <= sticky_flags | push_flags[7:4];
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = 4'b0000;
`endif

endmodule
